pc_seq_unit: RTL and testbench

Parametrised program-counter sequencer for the multicycle core: holds the PC, computes the next PC for increment, conditional branch, page jump and register jump, and adds a hardware return-address stack (RAS) for call/return. It replaces the fixed 10-bit PC register, the single-entry stack PC and the PC-source multiplexing. Widths, stack depth and reset vector are parameters.

---
 rtl/pcu_pkg.sv | 25 ++
 rtl/ras_lifo.sv | 75 +++++++
 rtl/pc_seq_unit.sv | 113 +++++++++++
 tb/tb_pc_seq_unit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pcu_pkg.sv
// Shared definitions for the program-counter sequencer: op encoding, op width
// and the immediate sign-extension helper used for branch offsets.
package pcu_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_HOLD   = 3'd0;
  localparam logic [OP_W-1:0] OP_INC    = 3'd1;
  localparam logic [OP_W-1:0] OP_BRANCH = 3'd2;
  localparam logic [OP_W-1:0] OP_JUMP   = 3'd3;
  localparam logic [OP_W-1:0] OP_JREG   = 3'd4;
  localparam logic [OP_W-1:0] OP_CALL   = 3'd5;
  localparam logic [OP_W-1:0] OP_RET    = 3'd6;

  // Sign-extend the low imm_w bits of imm to 32 bits; callers truncate to ADDR_W.
  function automatic logic [31:0] sext_imm(input logic [31:0] imm, input int unsigned imm_w);
    logic [31:0] sign_mask;
    sign_mask = ~((32'd1 << imm_w) - 32'd1);
    if (((imm >> (imm_w - 1)) & 32'd1) != 32'd0)
      return imm | sign_mask;
    else
      return imm & ~sign_mask;
  endfunction

endpackage

// File: rtl/ras_lifo.sv
// Return-address stack with flush-before-op semantics. With PCU_RAS_WRAP_EN
// defined the stack is circular and a push on full overwrites the oldest entry.
module ras_lifo #(
  parameter int W     = 10,
  parameter int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     top,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(DEPTH - 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] ptr_reg, ptr_next, ptr_inc, ptr_dec;
  logic [CNT_W-1:0] count_reg, count_next, count_base;
  logic             wr_en;

  // ptr_reg is the next slot to write; the newest entry sits one below it.
  assign ptr_inc = (ptr_reg == PTR_MAX) ? '0 : ptr_reg + 1'b1;
  assign ptr_dec = (ptr_reg == '0) ? PTR_MAX : ptr_reg - 1'b1;

  always_comb begin
    count_base = flush ? '0 : count_reg;
    count_next = count_base;
    ptr_next   = ptr_reg;
    wr_en      = 1'b0;
    if (push) begin
      if (count_base != DEPTH_C) begin
        wr_en      = 1'b1;
        ptr_next   = ptr_inc;
        count_next = count_base + 1'b1;
      end
`ifdef PCU_RAS_WRAP_EN
      else begin
        wr_en    = 1'b1;
        ptr_next = ptr_inc;
      end
`endif
    end else if (pop && count_base != '0) begin
      ptr_next   = ptr_dec;
      count_next = count_base - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_reg   <= '0;
      count_reg <= '0;
    end else begin
      ptr_reg   <= ptr_next;
      count_reg <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[ptr_reg] <= din;
  end

  assign count = count_reg;
  assign empty = (count_reg == '0);
  assign full  = (count_reg == DEPTH_C);
  assign top   = empty ? '0 : mem[ptr_dec];

endmodule

// File: rtl/pc_seq_unit.sv
// Program-counter sequencer: next-PC selection, PC register, sticky faults and
// the return-address stack. PCU_RAS_WRAP_EN selects the circular-stack build.
module pc_seq_unit
  import pcu_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int IMM_W     = 8,
  parameter int RAS_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  localparam int CNT_W = $clog2(RAS_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  input  logic [OP_W-1:0]   op,
  input  logic              cond,
  input  logic [IMM_W-1:0]  imm,
  input  logic [ADDR_W-1:0] reg_target,
  input  logic              flush,
  input  logic              fault_clr,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] ras_top,
  output logic [CNT_W-1:0]  ras_count,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              fault_ovf,
  output logic              fault_unf
);

`ifdef PCU_RAS_WRAP_EN
  localparam bit OVF_POSSIBLE = 1'b0;
`else
  localparam bit OVF_POSSIBLE = 1'b1;
`endif

  logic [ADDR_W-1:0] pc_reg, pc_next, pc_inc, pc_branch, pc_jump;
  logic              ovf_reg, ovf_next, unf_reg, unf_next;
  logic              push, pop, flush_q, empty_eff, full_eff;

  assign pc_inc    = pc_reg + 1'b1;
  assign pc_branch = pc_reg + ADDR_W'(sext_imm(32'(imm), IMM_W));
  assign pc_jump   = {pc_reg[ADDR_W-1:IMM_W], imm};

  // A flush applies before the op, so the op sees an empty stack.
  assign flush_q   = op_valid && flush;
  assign empty_eff = flush_q || ras_empty;
  assign full_eff  = !flush_q && ras_full;

  always_comb begin
    pc_next  = pc_reg;
    ovf_next = ovf_reg;
    unf_next = unf_reg;
    push     = 1'b0;
    pop      = 1'b0;
    if (op_valid) begin
      if (fault_clr) begin
        ovf_next = 1'b0;
        unf_next = 1'b0;
      end
      case (op)
        OP_INC:    pc_next = pc_inc;
        OP_BRANCH: pc_next = cond ? pc_branch : pc_inc;
        OP_JUMP:   pc_next = pc_jump;
        OP_JREG:   pc_next = reg_target;
        OP_CALL: begin
          push    = 1'b1;
          pc_next = pc_jump;
          if (full_eff && OVF_POSSIBLE) ovf_next = 1'b1;
        end
        OP_RET: begin
          if (empty_eff) begin
            pc_next  = pc_inc;
            unf_next = 1'b1;
          end else begin
            pop     = 1'b1;
            pc_next = ras_top;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_reg  <= RESET_PC;
      ovf_reg <= 1'b0;
      unf_reg <= 1'b0;
    end else begin
      pc_reg  <= pc_next;
      ovf_reg <= ovf_next;
      unf_reg <= unf_next;
    end
  end

  ras_lifo #(.W(ADDR_W), .DEPTH(RAS_DEPTH)) u_ras (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush_q),
    .din   (pc_inc),
    .top   (ras_top),
    .count (ras_count),
    .empty (ras_empty),
    .full  (ras_full)
  );

  assign pc        = pc_reg;
  assign fault_ovf = ovf_reg;
  assign fault_unf = unf_reg;

endmodule

// File: tb/tb_pc_seq_unit.sv
// Self-checking bench for pc_seq_unit: directed scenarios plus randomized ops
// compared every cycle against a queue-based model (honours PCU_RAS_WRAP_EN).
module tb_pc_seq_unit;
  import pcu_pkg::*;

  localparam int ADDR_W    = 10;
  localparam int IMM_W     = 8;
  localparam int RAS_DEPTH = 8;
  localparam int RESET_PC  = 0;
  localparam int CNT_W     = $clog2(RAS_DEPTH + 1);
  localparam int AMASK     = (1 << ADDR_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              op_valid = 1'b0;
  logic [OP_W-1:0]   op = '0;
  logic              cond = 1'b0;
  logic [IMM_W-1:0]  imm = '0;
  logic [ADDR_W-1:0] reg_target = '0;
  logic              flush = 1'b0;
  logic              fault_clr = 1'b0;
  logic [ADDR_W-1:0] pc, ras_top;
  logic [CNT_W-1:0]  ras_count;
  logic              ras_empty, ras_full, fault_ovf, fault_unf;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Reference model state
  int m_pc;
  int m_stk[$];
  bit m_ovf, m_unf;

  pc_seq_unit #(.ADDR_W(ADDR_W), .IMM_W(IMM_W), .RAS_DEPTH(RAS_DEPTH),
                .RESET_PC(ADDR_W'(RESET_PC))) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .cond(cond), .imm(imm),
    .reg_target(reg_target), .flush(flush), .fault_clr(fault_clr), .pc(pc),
    .ras_top(ras_top), .ras_count(ras_count), .ras_empty(ras_empty),
    .ras_full(ras_full), .fault_ovf(fault_ovf), .fault_unf(fault_unf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RESET_PC;
    m_stk.delete();
    m_ovf = 0;
    m_unf = 0;
  endtask

  task automatic model_step(input bit v, input int o, input bit c, input int im,
                            input int rt, input bit fl, input bit fc);
    int nxt, off;
    bit ovf_new, unf_new;
    if (!v) return;
    ovf_new = 0;
    unf_new = 0;
    if (fl) m_stk.delete();
    nxt = m_pc;
    off = (im >= (1 << (IMM_W - 1))) ? im - (1 << IMM_W) : im;
    case (o)
      1: nxt = m_pc + 1;
      2: nxt = c ? m_pc + off : m_pc + 1;
      3: nxt = (m_pc & ~((1 << IMM_W) - 1)) | im;
      4: nxt = rt;
      5: begin
        if (m_stk.size() < RAS_DEPTH) m_stk.push_back((m_pc + 1) & AMASK);
        else begin
`ifdef PCU_RAS_WRAP_EN
          void'(m_stk.pop_front());
          m_stk.push_back((m_pc + 1) & AMASK);
`else
          ovf_new = 1;
`endif
        end
        nxt = (m_pc & ~((1 << IMM_W) - 1)) | im;
      end
      6: begin
        if (m_stk.size() == 0) begin
          nxt = m_pc + 1;
          unf_new = 1;
        end else nxt = m_stk.pop_back();
      end
      default: nxt = m_pc;
    endcase
    if (fc) begin
      m_ovf = 0;
      m_unf = 0;
    end
    if (ovf_new) m_ovf = 1;
    if (unf_new) m_unf = 1;
    m_pc = nxt & AMASK;
  endtask

  // Single compare process: every cycle, shortly after the active edge.
  always @(posedge clk) begin
    #1;
    if (cmp_en) begin
      check("pc", int'(pc), m_pc);
      check("ras_count", int'(ras_count), m_stk.size());
      check("ras_top", int'(ras_top), (m_stk.size() != 0) ? m_stk[$] : 0);
      check("ras_empty", int'(ras_empty), int'(m_stk.size() == 0));
      check("ras_full", int'(ras_full), int'(m_stk.size() == RAS_DEPTH));
      check("fault_ovf", int'(fault_ovf), int'(m_ovf));
      check("fault_unf", int'(fault_unf), int'(m_unf));
    end
  end

  task automatic do_op(input bit v, input int o, input bit c, input int im,
                       input int rt, input bit fl, input bit fc);
    @(negedge clk);
    op_valid   = v;
    op         = OP_W'(o);
    cond       = c;
    imm        = IMM_W'(im);
    reg_target = ADDR_W'(rt);
    flush      = fl;
    fault_clr  = fc;
    @(posedge clk);
    model_step(v, o, c, im, rt, fl, fc);
    #2;
    $display("op v=%0d op=%0d cond=%0d imm=%0h rt=%0h fl=%0d fc=%0d -> pc=%0h top=%0h cnt=%0d ovf=%0d unf=%0d",
             v, o, c, im, rt, fl, fc, pc, ras_top, ras_count, fault_ovf, fault_unf);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    // Reset state, checked directly against literals
    check("rst_pc", int'(pc), RESET_PC);
    check("rst_count", int'(ras_count), 0);
    check("rst_empty", int'(ras_empty), 1);
    check("rst_full", int'(ras_full), 0);
    check("rst_top", int'(ras_top), 0);
    @(negedge clk);
    rst = 1'b1;
    cmp_en = 1'b1;

    // 1: three increments
    repeat (3) do_op(1, 1, 0, 0, 0, 0, 0);
    check("t1_pc", int'(pc), 3);
    check("t1_faults", int'({fault_ovf, fault_unf}), 0);

    // 2: wrap and negative branch
    do_op(1, 4, 0, 0, 'h3FE, 0, 0);
    do_op(1, 1, 0, 0, 0, 0, 0);
    check("t2_pc_3ff", int'(pc), 'h3FF);
    do_op(1, 1, 0, 0, 0, 0, 0);
    check("t2_pc_wrap", int'(pc), 0);
    do_op(1, 2, 1, 'hFE, 0, 0, 0);
    check("t2_branch_taken", int'(pc), 'h3FE);
    do_op(1, 2, 0, 'hFE, 0, 0, 0);
    check("t2_branch_not", int'(pc), 'h3FF);

    // 3: call / return
    do_op(1, 4, 0, 0, 'h105, 0, 0);
    do_op(1, 5, 0, 'h40, 0, 0, 0);
    check("t3_call_pc", int'(pc), 'h140);
    check("t3_call_top", int'(ras_top), 'h106);
    check("t3_call_cnt", int'(ras_count), 1);
    do_op(1, 6, 0, 0, 0, 0, 0);
    check("t3_ret_pc", int'(pc), 'h106);
    check("t3_ret_cnt", int'(ras_count), 0);

    // 4: nine nested calls, return addresses 1..9
    do_op(1, 4, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 9; k++) do_op(1, 5, 0, k, 0, 0, 0);
    check("t4_cnt", int'(ras_count), 8);
`ifdef PCU_RAS_WRAP_EN
    check("t4_ovf", int'(fault_ovf), 0);
`else
    check("t4_ovf", int'(fault_ovf), 1);
`endif
    for (int k = 0; k < 8; k++) begin
      do_op(1, 6, 0, 0, 0, 0, 0);
`ifdef PCU_RAS_WRAP_EN
      check("t4_ret_pc", int'(pc), 9 - k);
`else
      check("t4_ret_pc", int'(pc), 8 - k);
`endif
    end
    check("t4_empty", int'(ras_empty), 1);

    // 5: underflow and fault clear
    do_op(1, 0, 0, 0, 0, 0, 1);
    do_op(1, 4, 0, 0, 'h020, 0, 0);
    do_op(1, 6, 0, 0, 0, 0, 0);
    check("t5_unf_pc", int'(pc), 'h021);
    check("t5_unf", int'(fault_unf), 1);
    do_op(1, 0, 0, 0, 0, 0, 1);
    check("t5_clr", int'(fault_unf), 0);
    do_op(1, 6, 0, 0, 0, 0, 1);
    check("t5_clr_vs_new", int'(fault_unf), 1);

    // 6: flush with call, then asynchronous reset mid-cycle
    for (int k = 0; k < 3; k++) do_op(1, 5, 0, 'h30 + k, 0, 0, 0);
    check("t6_cnt3", int'(ras_count), 3);
    do_op(1, 4, 0, 0, 'h200, 0, 0);
    do_op(1, 5, 0, 'h10, 0, 1, 0);
    check("t6_flush_cnt", int'(ras_count), 1);
    check("t6_flush_top", int'(ras_top), 'h201);
    check("t6_flush_pc", int'(pc), 'h210);
    do_op(1, 5, 0, 'h55, 0, 0, 0);
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    check("t6_async_pc", int'(pc), RESET_PC);
    check("t6_async_cnt", int'(ras_count), 0);
    @(negedge clk);
    op_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Randomized phase
    for (int i = 0; i < 3000; i++) begin
      do_op($urandom_range(7) != 0, $urandom_range(7), $urandom_range(1),
            $urandom_range((1 << IMM_W) - 1), $urandom_range(AMASK),
            $urandom_range(15) == 0, $urandom_range(15) == 0);
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
